// File: rtl/axi4lite_pc_monitor.sv
// Passive AXI4-Lite protocol monitor: tracks outstanding transfers, checks handshake
// stability, response legality and VALID wait timeouts, and reports sticky error flags.
module axi4lite_pc_monitor #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MAXWBURSTS   = 4,
    parameter int MAXRBURSTS   = 4,
    parameter int MAXWAITS     = 16,
    parameter int RecMaxWaitOn = 1
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic [ADDR_WIDTH-1:0]   AWADDR,
    input  logic [2:0]              AWPROT,
    input  logic                    AWVALID,
    input  logic                    AWREADY,
    input  logic [DATA_WIDTH-1:0]   WDATA,
    input  logic [DATA_WIDTH/8-1:0] WSTRB,
    input  logic                    WVALID,
    input  logic                    WREADY,
    input  logic [1:0]              BRESP,
    input  logic                    BVALID,
    input  logic                    BREADY,
    input  logic [ADDR_WIDTH-1:0]   ARADDR,
    input  logic [2:0]              ARPROT,
    input  logic                    ARVALID,
    input  logic                    ARREADY,
    input  logic [DATA_WIDTH-1:0]   RDATA,
    input  logic [1:0]              RRESP,
    input  logic                    RVALID,
    input  logic                    RREADY,
    input  logic                    err_clear,
    output logic [11:0]             err_flags,
    output logic                    err_any,
    output logic [3:0]              first_err,
    output logic                    first_err_vld,
    output logic [7:0]              wr_outstanding,
    output logic [7:0]              rd_outstanding
);

    localparam int NCH    = 5;
    localparam int WAIT_W = $clog2(MAXWAITS + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAXWAITS);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAXWAITS - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [8:0]        WMAX      = 9'(MAXWBURSTS);
    localparam logic [8:0]        RMAX      = 9'(MAXRBURSTS);

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
        $error("axi4lite_pc_monitor: DATA_WIDTH must be 32 or 64");
    end
    if (MAXWAITS < 1) begin : g_bad_maxwaits
        $error("axi4lite_pc_monitor: MAXWAITS must be at least 1");
    end
    if (MAXWBURSTS < 1 || MAXWBURSTS > 255 || MAXRBURSTS < 1 || MAXRBURSTS > 255) begin : g_bad_bursts
        $error("axi4lite_pc_monitor: MAXWBURSTS/MAXRBURSTS must be in 1..255");
    end

    // Saturating up/down step; simultaneous inc and dec cancel out.
    function automatic logic [8:0] cnt_step(input logic [8:0] cnt, input logic inc,
                                            input logic dec, input logic [8:0] max);
        logic [8:0] nxt;
        nxt = cnt;
        if (inc && !dec) begin
            if (cnt < max) nxt = cnt + 9'd1;
            else           nxt = cnt;
        end else if (dec && !inc) begin
            if (cnt != 9'd0) nxt = cnt - 9'd1;
            else             nxt = cnt;
        end else begin
            nxt = cnt;
        end
        return nxt;
    endfunction

    function automatic logic [3:0] lowest_idx(input logic [11:0] v);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    function automatic logic [7:0] sat8(input logic [8:0] v);
        return v[8] ? 8'hFF : v[7:0];
    endfunction

    logic [NCH-1:0] valid_s, ready_s, changed_s, stab_err_s, to_s;
    logic aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
    logic aw_ovf_s, w_ovf_s, ar_ovf_s;
    logic [11:0] err_now_s;

    logic [ADDR_WIDTH+2:0]           aw_pay_s, ar_pay_s, aw_pay_q, ar_pay_q;
    logic [DATA_WIDTH+DATA_WIDTH/8-1:0] w_pay_s, w_pay_q;
    logic [1:0]                      b_pay_q;
    logic [DATA_WIDTH+1:0]           r_pay_s, r_pay_q;
    logic [NCH-1:0]                  stall_q;
    logic [NCH-1:0][WAIT_W-1:0]      wait_q, wait_d;

    logic [8:0]  aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d, ar_cnt_q, ar_cnt_d;
    logic [8:0]  wr_min_s;
    logic [11:0] err_flags_q, err_flags_d;
    logic [3:0]  first_err_q, first_err_d;
    logic        first_vld_q, first_vld_d;
    logic        err_any_q;
    logic [7:0]  wr_out_q, rd_out_q;

    assign valid_s  = {RVALID, BVALID, ARVALID, WVALID, AWVALID};
    assign ready_s  = {RREADY, BREADY, ARREADY, WREADY, AWREADY};
    assign aw_hs_s  = AWVALID & AWREADY;
    assign w_hs_s   = WVALID & WREADY;
    assign b_hs_s   = BVALID & BREADY;
    assign ar_hs_s  = ARVALID & ARREADY;
    assign r_hs_s   = RVALID & RREADY;
    assign aw_pay_s = {AWADDR, AWPROT};
    assign w_pay_s  = {WDATA, WSTRB};
    assign ar_pay_s = {ARADDR, ARPROT};
    assign r_pay_s  = {RDATA, RRESP};

    // Stability, wait-timeout and counter next-state evaluation.
    always_comb begin
        changed_s[0] = (aw_pay_s != aw_pay_q);
        changed_s[1] = (w_pay_s != w_pay_q);
        changed_s[2] = (ar_pay_s != ar_pay_q);
        changed_s[3] = (BRESP != b_pay_q);
        changed_s[4] = (r_pay_s != r_pay_q);
        stab_err_s   = stall_q & (~valid_s | changed_s);
        wait_d       = wait_q;
        to_s         = {NCH{1'b0}};
        for (int c = 0; c < NCH; c++) begin
            if (valid_s[c] && !ready_s[c]) begin
                if (wait_q[c] == WAIT_MAX) wait_d[c] = wait_q[c];
                else                       wait_d[c] = wait_q[c] + WAIT_ONE;
                to_s[c] = (wait_q[c] == WAIT_LAST);
            end else begin
                wait_d[c] = {WAIT_W{1'b0}};
                to_s[c]   = 1'b0;
            end
        end
        aw_ovf_s = aw_hs_s & ~b_hs_s & (aw_cnt_q >= WMAX);
        w_ovf_s  = w_hs_s & ~b_hs_s & (w_cnt_q >= WMAX);
        ar_ovf_s = ar_hs_s & ~r_hs_s & (ar_cnt_q >= RMAX);
        aw_cnt_d = cnt_step(aw_cnt_q, aw_hs_s, b_hs_s, WMAX);
        w_cnt_d  = cnt_step(w_cnt_q, w_hs_s, b_hs_s, WMAX);
        ar_cnt_d = cnt_step(ar_cnt_q, ar_hs_s, r_hs_s, RMAX);
        wr_min_s = (aw_cnt_d < w_cnt_d) ? aw_cnt_d : w_cnt_d;
    end

    // Per-rule error detection and sticky capture with err_clear priority to new errors.
    always_comb begin
        err_now_s[4:0] = stab_err_s;
        err_now_s[5]   = BVALID & (BRESP == 2'b01);
        err_now_s[6]   = RVALID & (RRESP == 2'b01);
        err_now_s[7]   = BVALID & ((aw_cnt_q == 9'd0) | (w_cnt_q == 9'd0));
        err_now_s[8]   = RVALID & (ar_cnt_q == 9'd0);
        err_now_s[9]   = aw_ovf_s | w_ovf_s;
        err_now_s[10]  = ar_ovf_s;
        err_now_s[11]  = (RecMaxWaitOn != 0) ? (|to_s) : 1'b0;
        if (err_clear) begin
            err_flags_d = err_now_s;
            first_vld_d = |err_now_s;
            first_err_d = lowest_idx(err_now_s);
        end else if (!first_vld_q && (|err_now_s)) begin
            err_flags_d = err_flags_q | err_now_s;
            first_vld_d = 1'b1;
            first_err_d = lowest_idx(err_now_s);
        end else begin
            err_flags_d = err_flags_q | err_now_s;
            first_vld_d = first_vld_q;
            first_err_d = first_err_q;
        end
    end

    // History, counters and registered outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            aw_pay_q    <= '0;
            w_pay_q     <= '0;
            ar_pay_q    <= '0;
            b_pay_q     <= 2'b00;
            r_pay_q     <= '0;
            stall_q     <= {NCH{1'b0}};
            wait_q      <= '0;
            aw_cnt_q    <= 9'd0;
            w_cnt_q     <= 9'd0;
            ar_cnt_q    <= 9'd0;
            err_flags_q <= 12'h000;
            first_err_q <= 4'd0;
            first_vld_q <= 1'b0;
            err_any_q   <= 1'b0;
            wr_out_q    <= 8'd0;
            rd_out_q    <= 8'd0;
        end else begin
            aw_pay_q    <= aw_pay_s;
            w_pay_q     <= w_pay_s;
            ar_pay_q    <= ar_pay_s;
            b_pay_q     <= BRESP;
            r_pay_q     <= r_pay_s;
            stall_q     <= valid_s & ~ready_s;
            wait_q      <= wait_d;
            aw_cnt_q    <= aw_cnt_d;
            w_cnt_q     <= w_cnt_d;
            ar_cnt_q    <= ar_cnt_d;
            err_flags_q <= err_flags_d;
            first_err_q <= first_err_d;
            first_vld_q <= first_vld_d;
            err_any_q   <= |err_flags_d;
            wr_out_q    <= sat8(wr_min_s);
            rd_out_q    <= sat8(ar_cnt_d);
        end
    end

    assign err_flags      = err_flags_q;
    assign err_any        = err_any_q;
    assign first_err      = first_err_q;
    assign first_err_vld  = first_vld_q;
    assign wr_outstanding = wr_out_q;
    assign rd_outstanding = rd_out_q;

endmodule
